square_fsm: RTL and testbench
=============================

Name: square_fsm

Overview:
Iterative integer squarer, the inverse companion of the sqrt FSM block: takes an unsigned DATA_W-bit operand and produces its exact 2*DATA_W-bit square.
- Method: sum of the first n odd numbers (n² = 1+3+...+(2n-1)), one addition per clock; no multiplier.
- Same enb/busy style as the sqrt block, so the two can be chained for round-trip checks.
- Adds a one-cycle done_o strobe.

Parameters:
DATA_W, 8, operand width; result width is 2*DATA_W

Ports:
clk  input  1  system clock, rising edge
rstn_i  input  1  asynchronous active-low reset
enb_i  input  1  start request; sampled only in IDLE
dt_i  input  DATA_W  unsigned operand n; captured on the accepting edge only
dt_o  output  2*DATA_W  registered result n²; holds until the next completion
busy_o  output  1  high while state != IDLE
done_o  output  1  one-cycle strobe; dt_o valid in the same cycle

Behaviour:
Reset (asynchronous, rstn_i=0): state=IDLE, cnt=0, acc=0, odd=1, dt_o=0, done_o=0, busy_o=0. Reset mid-operation aborts the operation with no done_o.

Registers:
- cnt: DATA_W bits, remaining iterations
- acc: 2*DATA_W bits, running sum
- odd: DATA_W+1 bits, current odd term (max 2*255+1=511 at DATA_W=8)

States:
- IDLE: if enb_i=1 at edge E0: cnt<=dt_i, acc<=0, odd<=1, go to ACC. Otherwise stay.
- ACC, cnt!=0: acc<=acc+odd, odd<=odd+2, cnt<=cnt-1.
- ACC, cnt==0: dt_o<=acc, done_o<=1, go to DONE.
- DONE: done_o<=0, go to IDLE unconditionally.

busy_o: decoded from the state register only (glitch-free, no combinational path from inputs).

Timing for operand n:
- The n additions occur at edges E1..En.
- At edge E(n+1): dt_o=n² and done_o=1.
- At edge E(n+2): done_o=0 and state=IDLE.
- busy_o is high for exactly n+2 cycles.
- Latency from accepting edge to done_o is n+1 cycles. Minimum is 1 (n=0); maximum is 256 (n=255, DATA_W=8).

Boundary rules:
- enb_i and dt_i are ignored while busy_o=1, and changing dt_i mid-operation has no effect.
- enb_i held high continuously gives back-to-back operations: a new accept happens on the first edge in IDLE, i.e. one idle cycle between done_o pulses.
- n=0: no additions; dt_o=0 with done_o one cycle after accept.
- No overflow is possible: (2^DATA_W-1)² < 2^(2*DATA_W). The odd register never wraps.
- dt_o changes only on completion edges and on reset.

Decomposition:
Package square_pkg:
- DATA_W default constant
- typedef enum logic [1:0] {IDLE, ACC, DONE} square_state_t

No sub-module: the datapath (three registers plus one adder and one incrementer) lives in square_fsm. The package is shared with the bench reference model.

Test Plan:
- Reset then enb_i=1, dt_i=0 -> busy_o high 2 cycles, done_o after 1 cycle, dt_o=0.
- dt_i=15, one-cycle enb_i -> done_o at accept+16 cycles, dt_o=225, busy_o high 17 cycles, single done_o pulse.
- dt_i=255 -> dt_o=65025 at accept+256 cycles, no overflow. Sweep 0..255 with model n*n: 0 mismatches.
- Accept dt_i=10, then pulse enb_i with dt_i=3 at cycle 4 while busy -> ignored, result 100, exactly one done_o.
- Accept dt_i=200, drive rstn_i=0 at cycle 50 -> immediately busy_o=0, done_o=0, dt_o=0. Release, then dt_i=7 -> dt_o=49.
- enb_i held high, operands 4 then 9 -> done_o pulses with dt_o=16 then 81, separated by the one idle cycle. Chain dt_o into the sqrt block for a round-trip check.

Source files
------------

// File: rtl/square_pkg.sv
// Shared types and defaults for the iterative squarer and its reference model.
package square_pkg;

    localparam int DEF_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } square_state_t;

endpackage

// File: rtl/square_fsm.sv
// Iterative squarer: n^2 built as the sum of the first n odd numbers,
// one addition per clock, with a one-cycle done strobe.
module square_fsm
    import square_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic                  clk,
    input  logic                  rstn_i,
    input  logic                  enb_i,
    input  logic [DATA_W-1:0]     dt_i,
    output logic [2*DATA_W-1:0]   dt_o,
    output logic                  busy_o,
    output logic                  done_o
);

    square_state_t           state_q;
    logic [DATA_W-1:0]       cnt_q;
    logic [2*DATA_W-1:0]     acc_q;
    logic [DATA_W:0]         odd_q;
    logic [2*DATA_W-1:0]     dt_q;
    logic                    done_q;

    // The odd term reaches at most 2*(2^DATA_W-1)+1, so DATA_W+1 bits never wrap.
    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            odd_q   <= (DATA_W+1)'(1);
            dt_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (enb_i) begin
                        cnt_q   <= dt_i;
                        acc_q   <= '0;
                        odd_q   <= (DATA_W+1)'(1);
                        state_q <= ACC;
                    end
                end
                ACC: begin
                    if (cnt_q != '0) begin
                        acc_q <= acc_q + (2*DATA_W)'(odd_q);
                        odd_q <= odd_q + (DATA_W+1)'(2);
                        cnt_q <= cnt_q - DATA_W'(1);
                    end else begin
                        dt_q    <= acc_q;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign dt_o   = dt_q;
    assign done_o = done_q;
    assign busy_o = (state_q != IDLE);

endmodule

// File: tb/tb_square_fsm.sv
// Self-checking bench for square_fsm: scoreboard of expected squares popped on
// each done strobe, plus per-scenario timing checks.
module tb_square_fsm;
    import square_pkg::*;

    localparam int W = DEF_DATA_W;

    logic             clk;
    logic             rstn_i;
    logic             enb_i;
    logic [W-1:0]     dt_i;
    logic [2*W-1:0]   dt_o;
    logic             busy_o;
    logic             done_o;

    typedef struct {
        int n;
        int sq;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    square_fsm #(.DATA_W(W)) dut (
        .clk    (clk),
        .rstn_i (rstn_i),
        .enb_i  (enb_i),
        .dt_i   (dt_i),
        .dt_o   (dt_o),
        .busy_o (busy_o),
        .done_o (done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in for the sqrt companion block: floor square root by search.
    function automatic int isqrt(input int v);
        int r;
        r = 0;
        while ((r + 1) * (r + 1) <= v) r++;
        return r;
    endfunction

    // Scoreboard: every done strobe must match the oldest outstanding operand.
    always @(negedge clk) begin
        if (rstn_i && done_o) begin
            exp_t e;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected_done: dt_o=%0d with no pending operand", dt_o);
            end else begin
                e = exp_q.pop_front();
                if (int'(dt_o) !== e.sq) begin
                    errors++;
                    $display("FAIL sb_result n=%0d: got %0d expected %0d", e.n, dt_o, e.sq);
                end
                checks++;
                if (isqrt(int'(dt_o)) !== e.n) begin
                    errors++;
                    $display("FAIL sb_roundtrip n=%0d: sqrt(dt_o)=%0d", e.n, isqrt(int'(dt_o)));
                end
            end
        end
    end

    // Pulse enb_i for one cycle with operand n and follow the operation to IDLE.
    // Index j counts negedges after the accepting edge (j=0 right after it).
    task automatic run_op(input int n, output int lat, output int busy_n, output int done_n);
        int j;
        exp_t e;
        lat = -1; busy_n = 0; done_n = 0;
        @(negedge clk);
        enb_i = 1'b1;
        dt_i  = W'(n);
        e.n = n; e.sq = n * n;
        exp_q.push_back(e);
        @(negedge clk);
        enb_i = 1'b0;
        j = 0;
        while (j < 400) begin
            if (busy_o) busy_n++;
            if (done_o) begin
                done_n++;
                if (lat < 0) lat = j;
            end
            if (!busy_o) break;
            @(negedge clk);
            j++;
        end
        if (j >= 400) begin
            checks++; errors++;
            $display("FAIL op_timeout n=%0d: still busy after %0d cycles", n, j);
        end
    endtask

    task automatic check_op(input string name, input int n);
        int lat, bn, dn;
        run_op(n, lat, bn, dn);
        checks++;
        if (lat !== n + 1) begin
            errors++;
            $display("FAIL %s_latency n=%0d: got %0d expected %0d", name, n, lat, n + 1);
        end
        checks++;
        if (bn !== n + 2) begin
            errors++;
            $display("FAIL %s_busy n=%0d: got %0d expected %0d", name, n, bn, n + 2);
        end
        checks++;
        if (dn !== 1) begin
            errors++;
            $display("FAIL %s_done_count n=%0d: got %0d expected 1", name, n, dn);
        end
    endtask

    task automatic test_reset();
        rstn_i = 1'b0; enb_i = 1'b0; dt_i = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (busy_o !== 1'b0 || done_o !== 1'b0 || dt_o !== '0) begin
            errors++;
            $display("FAIL reset_state: busy=%b done=%b dt_o=%0d expected 0/0/0", busy_o, done_o, dt_o);
        end
        rstn_i = 1'b1;
        @(negedge clk);
        checks++;
        if (busy_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: busy=%b expected 0", busy_o);
        end
    endtask

    task automatic test_zero();    check_op("zero", 0);    endtask
    task automatic test_fifteen(); check_op("n15", 15);    endtask
    task automatic test_max();     check_op("max", 255);   endtask

    task automatic test_sweep();
        for (int n = 0; n < 256; n++) check_op("sweep", n);
    endtask

    task automatic test_ignore_busy();
        int j, dn;
        exp_t e;
        @(negedge clk);
        enb_i = 1'b1; dt_i = W'(10);
        e.n = 10; e.sq = 100;
        exp_q.push_back(e);
        @(negedge clk);
        enb_i = 1'b0;
        j = 0; dn = 0;
        while (j < 40) begin
            if (j == 4) begin enb_i = 1'b1; dt_i = W'(3); end
            if (j == 5) enb_i = 1'b0;
            if (done_o) dn++;
            if (!busy_o) break;
            @(negedge clk);
            j++;
        end
        enb_i = 1'b0;
        checks++;
        if (dn !== 1) begin
            errors++;
            $display("FAIL ignore_done_count: got %0d expected 1", dn);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (busy_o !== 1'b0 || dt_o !== 16'd100) begin
            errors++;
            $display("FAIL ignore_no_restart: busy=%b dt_o=%0d expected 0/100", busy_o, dt_o);
        end
    endtask

    task automatic test_reset_abort();
        int lat, bn, dn;
        @(negedge clk);
        enb_i = 1'b1; dt_i = W'(200);
        @(negedge clk);
        enb_i = 1'b0;
        repeat (49) @(negedge clk);
        #2 rstn_i = 1'b0;
        #1;
        checks++;
        if (busy_o !== 1'b0 || done_o !== 1'b0 || dt_o !== '0) begin
            errors++;
            $display("FAIL abort_reset: busy=%b done=%b dt_o=%0d expected 0/0/0", busy_o, done_o, dt_o);
        end
        @(negedge clk);
        rstn_i = 1'b1;
        run_op(7, lat, bn, dn);
        checks++;
        if (dt_o !== 16'd49 || lat !== 8) begin
            errors++;
            $display("FAIL abort_recover: dt_o=%0d lat=%0d expected 49/8", dt_o, lat);
        end
    endtask

    task automatic test_back_to_back();
        int j, d0, d1, idle_between;
        exp_t e;
        d0 = -1; d1 = -1; idle_between = 0;
        @(negedge clk);
        enb_i = 1'b1; dt_i = W'(4);
        e.n = 4; e.sq = 16;
        exp_q.push_back(e);
        @(negedge clk);
        dt_i = W'(9);
        e.n = 9; e.sq = 81;
        exp_q.push_back(e);
        j = 0;
        while (j < 30) begin
            if (done_o) begin
                if (d0 < 0) d0 = j;
                else if (d1 < 0) d1 = j;
            end
            if (d0 >= 0 && d1 < 0 && !busy_o) idle_between++;
            if (d0 >= 0 && busy_o && !done_o && j > d0 + 1) enb_i = 1'b0;
            @(negedge clk);
            j++;
        end
        enb_i = 1'b0;
        checks++;
        if (d0 !== 5 || d1 !== 17) begin
            errors++;
            $display("FAIL b2b_done_times: got %0d,%0d expected 5,17", d0, d1);
        end
        checks++;
        if (idle_between !== 1) begin
            errors++;
            $display("FAIL b2b_idle_gap: got %0d expected 1", idle_between);
        end
    endtask

    initial begin
        test_reset();
        test_zero();
        test_fifteen();
        test_max();
        test_sweep();
        test_ignore_busy();
        test_reset_abort();
        test_back_to_back();
        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() !== 0) begin
            errors++;
            $display("FAIL sb_leftover: %0d operands never completed", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
